// File: rtl/bp_upd_sched.sv
// bp_upd_sched -- branch-predictor update scheduler.
//
// Takes resolved-branch records from EX and does three things with them:
//   * computes the actual next PC and sends a one-cycle redirect to fetch
//     when the prediction was wrong,
//   * queues the records that need a predictor update (BTB/PHT/eval) and
//     replays them one per cycle, oldest first, on the o_upd_* port,
//   * optionally keeps branch / mispredict statistics.
//
// Ports:
//   i_clk, i_rst_n        clock (rising edge), asynchronous active-low reset
//   i_res_*, o_res_rdy    resolved-record valid/ready handshake and payload
//   o_upd_*               update strobes (btb/pht/eval) plus data from queue head
//   o_redirect_vld/_pc    registered mispredict redirect, one cycle long
//   i_freeze              holds update issue; strobes drop in the same cycle
//   i_drain_req           level request to empty the queue (no new accepts)
//   o_drain_done          one-cycle pulse once the queue has been emptied
//   o_stat_br_cnt         accepted branch/jump records (saturating)
//   o_stat_mispred_cnt    mispredicts (saturating)
//
// Build option: define BP_UPD_STATS_EN to include the statistics counters;
// without it both statistics ports are tied to zero.

module bp_upd_sched #(
  parameter int PC_WIDTH   = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_res_vld,
  output logic                o_res_rdy,
  input  logic [PC_WIDTH-1:0] i_res_pc,
  input  logic [PC_WIDTH-1:0] i_res_target,
  input  logic [PC_WIDTH-1:0] i_res_pred_npc,
  input  logic                i_res_is_br,
  input  logic                i_res_is_jmp,
  input  logic                i_res_taken,
  input  logic                i_res_pred_hit,
  input  logic                i_res_pred_glb,
  input  logic                i_res_pred_loc,
  output logic                o_upd_btb_vld,
  output logic                o_upd_pht_vld,
  output logic                o_upd_eval_vld,
  output logic                o_upd_taken,
  output logic                o_upd_pred_glb,
  output logic                o_upd_pred_loc,
  output logic [PC_WIDTH-1:0] o_upd_pc,
  output logic [PC_WIDTH-1:0] o_upd_br_addr,
  output logic                o_redirect_vld,
  output logic [PC_WIDTH-1:0] o_redirect_pc,
  input  logic                i_freeze,
  input  logic                i_drain_req,
  output logic                o_drain_done,
  output logic [31:0]         o_stat_br_cnt,
  output logic [31:0]         o_stat_mispred_cnt
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_HOLD, S_DRAIN} state_t;

  typedef struct packed {
    logic [PC_WIDTH-1:0] pc;
    logic [PC_WIDTH-1:0] target;
    logic                taken;
    logic                glb;
    logic                loc;
    logic                btb;
    logic                pht;
    logic                eval;
  } entry_t;

  entry_t              mem_q [FIFO_DEPTH];
  state_t              state_q, state_d;
  logic [CW-1:0]       count_q, count_d;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                redirect_vld_q, redirect_vld_d;
  logic [PC_WIDTH-1:0] redirect_pc_q, redirect_pc_d;
  logic                drain_done_q, drain_done_d;

  logic                ctrl_flow, br_taken, accept, mispred, push, pop;
  logic [PC_WIDTH-1:0] actual_npc;
  entry_t              new_entry, head;

  // Ready is forced low during reset so EX never hands over a record that
  // would be discarded.
  assign o_res_rdy = i_rst_n && (count_q < DEPTH_C) && (state_q != S_DRAIN);
  assign accept    = i_res_vld && o_res_rdy;

  assign ctrl_flow  = i_res_is_br || i_res_is_jmp;
  assign br_taken   = i_res_is_jmp || (i_res_is_br && i_res_taken);
  assign actual_npc = br_taken ? i_res_target : i_res_pc + PC_WIDTH'(4);
  assign mispred    = accept && ctrl_flow && (actual_npc != i_res_pred_npc);

  always_comb begin
    new_entry        = '0;
    new_entry.pc     = i_res_pc;
    new_entry.target = i_res_target;
    new_entry.taken  = i_res_taken;
    new_entry.glb    = i_res_pred_glb;
    new_entry.loc    = i_res_pred_loc;
    new_entry.pht    = i_res_is_br;
    new_entry.eval   = i_res_is_br && i_res_pred_hit;
    // BTB only needs writing when a taken transfer missed or hit with a stale target.
    new_entry.btb    = br_taken && (!i_res_pred_hit || (i_res_pred_npc != i_res_target));
  end

  // Records that update nothing only produce redirect/statistics effects.
  assign push = accept && (new_entry.pht || new_entry.eval || new_entry.btb);

  assign head = mem_q[rd_ptr_q];
  // Freeze gates issue combinationally so strobes drop in the cycle it rises.
  assign pop  = ((state_q == S_ISSUE) || (state_q == S_DRAIN)) && !i_freeze && (count_q != '0);

  assign o_upd_btb_vld  = pop && head.btb;
  assign o_upd_pht_vld  = pop && head.pht;
  assign o_upd_eval_vld = pop && head.eval;
  assign o_upd_taken    = head.taken;
  assign o_upd_pred_glb = head.glb;
  assign o_upd_pred_loc = head.loc;
  assign o_upd_pc       = head.pc;
  assign o_upd_br_addr  = head.target;

  assign o_redirect_vld = redirect_vld_q;
  assign o_redirect_pc  = redirect_pc_q;
  assign o_drain_done   = drain_done_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    redirect_vld_d = mispred;
    redirect_pc_d  = mispred ? actual_npc : redirect_pc_q;
  end

  // Next state looks at the post-push count so a record accepted in IDLE
  // issues in the very next cycle.
  always_comb begin
    state_d      = state_q;
    drain_done_d = 1'b0;
    case (state_q)
      S_IDLE, S_ISSUE: begin
        // A drain request still high in the completion cycle is not taken as
        // a new request, so a requester reacting to the pulse sees only one.
        if (i_drain_req && !drain_done_q) state_d = S_DRAIN;
        else if (i_freeze)                state_d = S_HOLD;
        else                              state_d = (count_d != '0) ? S_ISSUE : S_IDLE;
      end
      S_HOLD: begin
        if (!i_freeze) state_d = (count_d != '0) ? S_ISSUE : S_IDLE;
      end
      S_DRAIN: begin
        if (count_d == '0) begin
          state_d      = S_IDLE;
          drain_done_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q        <= S_IDLE;
      count_q        <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      redirect_vld_q <= 1'b0;
      redirect_pc_q  <= '0;
      drain_done_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      redirect_vld_q <= redirect_vld_d;
      redirect_pc_q  <= redirect_pc_d;
      drain_done_q   <= drain_done_d;
    end
  end

  // Queue storage carries no reset; validity is tracked by count/pointers.
  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q] <= new_entry;
  end

`ifdef BP_UPD_STATS_EN
  logic [31:0] br_cnt_q, br_cnt_d, mis_cnt_q, mis_cnt_d;

  always_comb begin
    br_cnt_d  = br_cnt_q;
    mis_cnt_d = mis_cnt_q;
    if (accept && ctrl_flow && (br_cnt_q != 32'hFFFF_FFFF)) br_cnt_d = br_cnt_q + 32'd1;
    if (mispred && (mis_cnt_q != 32'hFFFF_FFFF))            mis_cnt_d = mis_cnt_q + 32'd1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
    end else begin
      br_cnt_q  <= br_cnt_d;
      mis_cnt_q <= mis_cnt_d;
    end
  end

  assign o_stat_br_cnt      = br_cnt_q;
  assign o_stat_mispred_cnt = mis_cnt_q;
`else
  assign o_stat_br_cnt      = 32'd0;
  assign o_stat_mispred_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_bp_upd_sched.sv
// tb_bp_upd_sched -- self-checking bench for bp_upd_sched.
// Directed scenarios followed by a randomized run, all compared every cycle
// against a queue-based reference model of the scheduler's behaviour.

module tb_bp_upd_sched;

  localparam int DEPTH = 4;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_res_vld = 1'b0;
  logic        o_res_rdy;
  logic [31:0] i_res_pc = '0, i_res_target = '0, i_res_pred_npc = '0;
  logic        i_res_is_br = 1'b0, i_res_is_jmp = 1'b0, i_res_taken = 1'b0;
  logic        i_res_pred_hit = 1'b0, i_res_pred_glb = 1'b0, i_res_pred_loc = 1'b0;
  logic        o_upd_btb_vld, o_upd_pht_vld, o_upd_eval_vld;
  logic        o_upd_taken, o_upd_pred_glb, o_upd_pred_loc;
  logic [31:0] o_upd_pc, o_upd_br_addr;
  logic        o_redirect_vld;
  logic [31:0] o_redirect_pc;
  logic        i_freeze = 1'b0, i_drain_req = 1'b0;
  logic        o_drain_done;
  logic [31:0] o_stat_br_cnt, o_stat_mispred_cnt;

  always #5 i_clk = ~i_clk;

  bp_upd_sched #(.PC_WIDTH(32), .FIFO_DEPTH(DEPTH)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_res_vld(i_res_vld), .o_res_rdy(o_res_rdy),
    .i_res_pc(i_res_pc), .i_res_target(i_res_target), .i_res_pred_npc(i_res_pred_npc),
    .i_res_is_br(i_res_is_br), .i_res_is_jmp(i_res_is_jmp), .i_res_taken(i_res_taken),
    .i_res_pred_hit(i_res_pred_hit), .i_res_pred_glb(i_res_pred_glb), .i_res_pred_loc(i_res_pred_loc),
    .o_upd_btb_vld(o_upd_btb_vld), .o_upd_pht_vld(o_upd_pht_vld), .o_upd_eval_vld(o_upd_eval_vld),
    .o_upd_taken(o_upd_taken), .o_upd_pred_glb(o_upd_pred_glb), .o_upd_pred_loc(o_upd_pred_loc),
    .o_upd_pc(o_upd_pc), .o_upd_br_addr(o_upd_br_addr),
    .o_redirect_vld(o_redirect_vld), .o_redirect_pc(o_redirect_pc),
    .i_freeze(i_freeze), .i_drain_req(i_drain_req), .o_drain_done(o_drain_done),
    .o_stat_br_cnt(o_stat_br_cnt), .o_stat_mispred_cnt(o_stat_mispred_cnt)
  );

  // Reference model: queue of pending updates plus "held"/"draining" modes.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] target;
    bit taken, glb, loc, btb, pht, eval;
  } rec_t;

  rec_t        q[$];
  bit          held, draining, exp_redir, exp_done;
  logic [31:0] exp_redir_pc;
  int unsigned exp_br, exp_mis;
  int          checks = 0, failures = 0;
  int          issues_seen = 0, dones_seen = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    held = 0; draining = 0; exp_redir = 0; exp_done = 0;
    exp_redir_pc = '0; exp_br = 0; exp_mis = 0;
  endtask

  // Called at posedge+1 with inputs already driven: checks this cycle,
  // advances the model, and returns at posedge+1 of the next cycle.
  task automatic cycle();
    bit exp_rdy, can_issue, acc, ctrl, brt, mis, done_now;
    logic [31:0] npc;
    rec_t r, h;
    #1;
    exp_rdy = (i_rst_n === 1'b1) && !draining && (q.size() < DEPTH);
    chk("res_rdy", o_res_rdy, exp_rdy);
    can_issue = !held && !i_freeze && (q.size() > 0);
    if (can_issue) begin
      h = q[0];
      chk("upd_btb_vld", o_upd_btb_vld, h.btb);
      chk("upd_pht_vld", o_upd_pht_vld, h.pht);
      chk("upd_eval_vld", o_upd_eval_vld, h.eval);
      chk("upd_pc", o_upd_pc, h.pc);
      chk("upd_br_addr", o_upd_br_addr, h.target);
      chk("upd_taken", o_upd_taken, h.taken);
      chk("upd_glb", o_upd_pred_glb, h.glb);
      chk("upd_loc", o_upd_pred_loc, h.loc);
    end else begin
      chk("idle_btb_vld", o_upd_btb_vld, 0);
      chk("idle_pht_vld", o_upd_pht_vld, 0);
      chk("idle_eval_vld", o_upd_eval_vld, 0);
    end
    chk("redirect_vld", o_redirect_vld, exp_redir);
    if (exp_redir) chk("redirect_pc", o_redirect_pc, exp_redir_pc);
    chk("drain_done", o_drain_done, exp_done);
`ifdef BP_UPD_STATS_EN
    chk("stat_br", o_stat_br_cnt, exp_br);
    chk("stat_mis", o_stat_mispred_cnt, exp_mis);
`else
    chk("stat_br", o_stat_br_cnt, 0);
    chk("stat_mis", o_stat_mispred_cnt, 0);
`endif
    if (o_upd_btb_vld || o_upd_pht_vld || o_upd_eval_vld) issues_seen++;
    if (o_drain_done) dones_seen++;

    acc  = i_res_vld && exp_rdy;
    ctrl = i_res_is_br || i_res_is_jmp;
    brt  = i_res_is_jmp || (i_res_is_br && i_res_taken);
    npc  = brt ? i_res_target : i_res_pc + 32'd4;
    mis  = acc && ctrl && (npc != i_res_pred_npc);
    r.pc = i_res_pc; r.target = i_res_target; r.taken = i_res_taken;
    r.glb = i_res_pred_glb; r.loc = i_res_pred_loc;
    r.pht  = i_res_is_br;
    r.eval = i_res_is_br && i_res_pred_hit;
    r.btb  = brt && (!i_res_pred_hit || (i_res_pred_npc != i_res_target));
    exp_redir = mis;
    if (mis) exp_redir_pc = npc;
    if (acc && ctrl) exp_br++;
    if (mis) exp_mis++;
    if (can_issue) h = q.pop_front();
    if (acc && (r.pht || r.eval || r.btb)) q.push_back(r);

    done_now = exp_done;
    exp_done = 0;
    if (draining) begin
      if (q.size() == 0) begin
        exp_done = 1;
        draining = 0;
      end
    end else if (held) begin
      held = i_freeze;
    end else if (i_drain_req && !done_now) begin
      draining = 1;
    end else if (i_freeze) begin
      held = 1;
    end
    @(posedge i_clk);
    #1;
  endtask

  task automatic send(input bit br, input bit jmp, input logic [31:0] pc, input bit taken,
                      input logic [31:0] target, input bit hit, input logic [31:0] pnpc);
    i_res_vld = 1; i_res_is_br = br; i_res_is_jmp = jmp; i_res_pc = pc;
    i_res_taken = taken; i_res_target = target; i_res_pred_hit = hit;
    i_res_pred_npc = pnpc; i_res_pred_glb = taken; i_res_pred_loc = ~taken;
  endtask

  task automatic send_rand();
    int kind, sel;
    i_res_vld      = ($urandom_range(0, 3) != 0);
    kind           = $urandom_range(0, 4);
    i_res_is_br    = (kind == 1) || (kind == 3) || (kind == 4);
    i_res_is_jmp   = (kind == 2);
    i_res_pc       = $urandom & 32'h0000_0FFC;
    i_res_target   = $urandom & 32'h0000_0FFC;
    i_res_taken    = $urandom_range(0, 1);
    i_res_pred_hit = $urandom_range(0, 1);
    i_res_pred_glb = $urandom_range(0, 1);
    i_res_pred_loc = $urandom_range(0, 1);
    sel = $urandom_range(0, 2);
    i_res_pred_npc = (sel == 0) ? i_res_pc + 32'd4 : (sel == 1) ? i_res_target : ($urandom & 32'hFFC);
  endtask

  initial begin
    model_reset();
    // Reset state.
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_rdy", o_res_rdy, 0);
    chk("rst_redirect", o_redirect_vld, 0);
    chk("rst_drain_done", o_drain_done, 0);
    chk("rst_pht", o_upd_pht_vld, 0);
    chk("rst_stat_br", o_stat_br_cnt, 0);
    i_rst_n = 1;
    repeat (2) cycle();

    // Statistics: 5 branches, 2 of them mispredicted.
    for (int i = 0; i < 5; i++) begin
      if (i < 3) send(1, 0, 32'h400 + 32'(i * 16), 0, 32'h40, 1, 32'h404 + 32'(i * 16));
      else       send(1, 0, 32'h400 + 32'(i * 16), 1, 32'h40, 0, 32'h404 + 32'(i * 16));
      cycle();
    end
    i_res_vld = 0;
    #1;
`ifdef BP_UPD_STATS_EN
    chk("stat5_br", o_stat_br_cnt, 5);
    chk("stat5_mis", o_stat_mispred_cnt, 2);
`else
    chk("stat5_br", o_stat_br_cnt, 0);
    chk("stat5_mis", o_stat_mispred_cnt, 0);
`endif
    repeat (6) cycle();

    // Taken branch, BTB miss -> redirect and BTB+PHT update next cycle.
    send(1, 0, 32'h100, 1, 32'h80, 0, 32'h104);
    cycle();
    i_res_vld = 0;
    #1;
    chk("d1_redirect_vld", o_redirect_vld, 1);
    chk("d1_redirect_pc", o_redirect_pc, 32'h80);
    chk("d1_btb", o_upd_btb_vld, 1);
    chk("d1_pht", o_upd_pht_vld, 1);
    chk("d1_eval", o_upd_eval_vld, 0);
    chk("d1_br_addr", o_upd_br_addr, 32'h80);
    repeat (2) cycle();

    // Correctly predicted not-taken branch with BTB hit.
    send(1, 0, 32'h200, 0, 32'h300, 1, 32'h204);
    cycle();
    i_res_vld = 0;
    #1;
    chk("d2_redirect_vld", o_redirect_vld, 0);
    chk("d2_pht", o_upd_pht_vld, 1);
    chk("d2_eval", o_upd_eval_vld, 1);
    chk("d2_btb", o_upd_btb_vld, 0);
    repeat (2) cycle();

    // Frozen fill to full, then release.
    i_freeze = 1;
    for (int i = 0; i < 4; i++) begin
      send(1, 0, 32'h500 + 32'(i * 8), i[0], 32'h600 + 32'(i * 8), 0, 32'h504 + 32'(i * 8));
      cycle();
    end
    i_res_vld = 0;
    #1;
    chk("frz_rdy_full", o_res_rdy, 0);
    cycle();
    i_freeze = 0;
    cycle();
    issues_seen = 0;
    repeat (6) cycle();
    chk("frz_issue_count", issues_seen, 4);

    // Drain with three queued records.
    i_freeze = 1;
    for (int i = 0; i < 3; i++) begin
      send(1, 0, 32'h700 + 32'(i * 8), 1, 32'h780, 1, 32'h780);
      cycle();
    end
    i_res_vld = 0;
    i_freeze = 0;
    i_drain_req = 1;
    cycle();
    issues_seen = 0;
    dones_seen = 0;
    for (int k = 0; k < 12; k++) begin
      cycle();
      if (exp_done) break;
    end
    cycle();
    i_drain_req = 0;
    repeat (2) cycle();
    chk("drain_issue_count", issues_seen, 3);
    chk("drain_done_pulses", dones_seen, 1);

    // Reset with queued records mid-issue.
    i_freeze = 1;
    for (int i = 0; i < 3; i++) begin
      send(1, 0, 32'h900 + 32'(i * 4), 0, 32'h0, 0, 32'h904 + 32'(i * 4));
      cycle();
    end
    i_res_vld = 0;
    i_freeze = 0;
    repeat (2) cycle();
    #1;
    chk("prerst_pht", o_upd_pht_vld, 1);
    i_rst_n = 0;
    #1;
    chk("midrst_pht", o_upd_pht_vld, 0);
    chk("midrst_btb", o_upd_btb_vld, 0);
    chk("midrst_eval", o_upd_eval_vld, 0);
    chk("midrst_rdy", o_res_rdy, 0);
    @(posedge i_clk);
    #1;
    i_rst_n = 1;
    model_reset();
    repeat (4) cycle();

    // Randomized traffic with occasional freeze and drain requests.
    for (int n = 0; n < 600; n++) begin
      send_rand();
      if ($urandom_range(0, 5) == 0) i_freeze = ~i_freeze;
      i_drain_req = ($urandom_range(0, 19) == 0);
      cycle();
    end
    i_res_vld = 0;
    i_freeze = 0;
    i_drain_req = 0;
    repeat (8) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bp_upd_sched.md
BP_UPD_SCHED -- requirements
Module: bp_upd_sched

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 32, PC and target width.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, update-queue entries, power of two and at least 2.
REQ-003 SHALL have port i_clk  in  1  sole clock, all state on rising edge.
REQ-004 SHALL have port i_rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports i_res_vld in 1 / o_res_rdy out 1  resolved-branch record handshake from EX.
REQ-006 SHALL have ports i_res_pc, i_res_target, i_res_pred_npc  in  PC_WIDTH  branch PC, resolved target, predicted next PC.
REQ-007 SHALL have ports i_res_is_br, i_res_is_jmp, i_res_taken, i_res_pred_hit, i_res_pred_glb, i_res_pred_loc  in  1  conditional, unconditional, actual outcome, BTB hit, global prediction, local prediction.
REQ-008 SHALL have ports o_upd_btb_vld, o_upd_pht_vld, o_upd_eval_vld, o_upd_taken, o_upd_pred_glb, o_upd_pred_loc  out  1  predictor update strobes and data.
REQ-009 SHALL have ports o_upd_pc, o_upd_br_addr  out  PC_WIDTH  update PC and BTB target.
REQ-010 SHALL have ports o_redirect_vld out 1 / o_redirect_pc out PC_WIDTH  mispredict redirect to fetch.
REQ-011 SHALL have ports i_freeze in 1, i_drain_req in 1, o_drain_done out 1  hold updates, drain request (level), drain completion pulse.
REQ-012 SHALL have ports o_stat_br_cnt, o_stat_mispred_cnt  out  32  statistics counters.

Function
REQ-013 SHALL accept a record when i_res_vld and o_res_rdy are both high; o_res_rdy = (count < FIFO_DEPTH) and state != DRAIN.
REQ-014 SHALL compute actual_npc = (i_res_is_jmp or (i_res_is_br and i_res_taken)) ? i_res_target : i_res_pc + 4, truncated to PC_WIDTH.
REQ-015 SHALL flag mispredict on accept when (i_res_is_br or i_res_is_jmp) and actual_npc != i_res_pred_npc.
REQ-016 SHALL assert o_redirect_vld for exactly one cycle, the cycle after a mispredicting accept, with o_redirect_pc = actual_npc, registered.
REQ-017 SHALL derive per-record flags: upd_pht = i_res_is_br; upd_eval = i_res_is_br and i_res_pred_hit; upd_btb = (is_br and taken, or is_jmp) and (not pred_hit or pred_npc != target).
REQ-018 SHALL enqueue only records with at least one flag set; other accepted records generate redirect/statistics only.
REQ-019 SHALL drive update outputs combinationally from FIFO head in state ISSUE: strobes = head flags, o_upd_pc, o_upd_br_addr = target, taken/glb/loc from head; head popped that cycle.
REQ-020 SHALL issue at most one record per cycle, in acceptance order; earliest issue is the cycle after acceptance.
REQ-021 SHALL hold all update strobes low outside ISSUE; data outputs are don't-care when strobes are low.
REQ-022 SHALL implement FSM IDLE, ISSUE, HOLD, DRAIN: IDLE->ISSUE when count>0 and not i_freeze; ISSUE/IDLE->HOLD when i_freeze; HOLD->ISSUE/IDLE when i_freeze drops (by count); ISSUE->IDLE when last entry pops and no push.
REQ-023 SHALL enter DRAIN from IDLE/ISSUE when i_drain_req is high; in DRAIN issue while not frozen, gate strobes low while frozen; pulse o_drain_done one cycle when count reaches 0, then IDLE.
REQ-024 SHALL not enqueue when full even if a pop occurs the same cycle; simultaneous push and pop when not full keeps count unchanged.
REQ-025 SHALL wrap read/write pointers modulo FIFO_DEPTH.
REQ-026 SHALL gate strobes in the same cycle i_freeze rises; head entry retained.

Reset
REQ-027 SHALL, on i_rst_n low, asynchronously clear count, pointers, state to IDLE, o_redirect_vld, o_redirect_pc, o_drain_done, statistics to 0; mid-operation reset discards queued records.
REQ-028 SHALL hold o_res_rdy low while i_rst_n is low.

Configuration
REQ-029 SHALL, with BP_UPD_STATS_EN defined, increment o_stat_br_cnt per accepted is_br/is_jmp record and o_stat_mispred_cnt per mispredict, saturating at 32'hFFFF_FFFF.
REQ-030 SHALL, without BP_UPD_STATS_EN, tie both statistics ports to 0 with no counter logic.

Verification
REQ-031 Accept is_br, pc=0x100, taken=1, target=0x80, pred_hit=0, pred_npc=0x104 -> next cycle o_redirect_vld=1, o_redirect_pc=0x80, o_upd_btb_vld=1, o_upd_pht_vld=1, o_upd_eval_vld=0, o_upd_br_addr=0x80.
REQ-032 Accept is_br, pc=0x200, taken=0, pred_hit=1, pred_npc=0x204 -> no redirect; one cycle later o_upd_pht_vld=1, o_upd_eval_vld=1, o_upd_btb_vld=0.
REQ-033 i_freeze=1, push 4 records -> o_res_rdy=0 after 4th, no strobes; drop freeze -> 4 consecutive issue cycles in order, then IDLE.
REQ-034 3 queued, i_drain_req=1 -> o_res_rdy=0, 3 issues, o_drain_done single pulse the cycle count reaches 0.
REQ-035 i_rst_n low with 2 queued records mid-ISSUE -> all strobes 0 immediately, count 0, no issue after release.
REQ-036 With BP_UPD_STATS_EN, 5 branches, 2 mispredicts -> o_stat_br_cnt=5, o_stat_mispred_cnt=2; without it, both 0.
